iob_fifo_ctrl_t2p: RTL

- Synchronous FIFO controller that drives an external true two-port RAM (iob_ram_t2p style) from the upstream side.
- Owns the write/read pointers, level counter and full/empty flags.
- Translates the producer/consumer push/pop interface into RAM write-port and read-port strobes.
- Read data is the RAM's registered output, so pop latency is 1 cycle.

---
 rtl/iob_fifo_ctrl_t2p.sv | 115 +++++++++++
 1 files changed

// File: rtl/iob_fifo_ctrl_t2p.sv
// rtl/iob_fifo_ctrl_t2p.sv - FIFO controller driving an external true two-port RAM
// Optional sticky overflow/underflow flags: define IOB_FIFO_CTRL_T2P_ERR_EN.
module iob_fifo_ctrl_t2p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef IOB_FIFO_CTRL_T2P_ERR_EN
  input  logic              err_clr_i,
  output logic              w_overflow_o,
  output logic              r_underflow_o,
`endif
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] L_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_empty;
  logic              r_full;
  logic              r_valid;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W:0]   w_level_nxt;

  // Acceptance looks only at registered flags, so a push into an empty FIFO
  // never bypasses to the read side in the same cycle.
  assign w_push_ok = w_en_i & ~r_full;
  assign w_pop_ok  = r_en_i & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_nxt = r_level + L_ONE;
      2'b01:   w_level_nxt = r_level - L_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + ADDR_W'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == L_DEPTH);
      r_valid <= w_pop_ok;
    end
  end

  assign ext_mem_w_en_o   = w_push_ok;
  assign ext_mem_w_addr_o = r_wptr;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_pop_ok;
  assign ext_mem_r_addr_o = r_rptr;

  // The RAM output register holds between reads, so data passes straight through.
  assign r_data_o  = ext_mem_r_data_i;
  assign r_valid_o = r_valid;
  assign r_empty_o = r_empty;
  assign w_full_o  = r_full;
  assign level_o   = r_level;

`ifdef IOB_FIFO_CTRL_T2P_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = w_en_i & r_full & ~w_pop_ok;
  assign w_udf_set = r_en_i & r_empty;

  // A new error in the clearing cycle must not be lost, so set beats clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (err_clr_i) r_overflow <= 1'b0;
      if (w_udf_set)      r_underflow <= 1'b1;
      else if (err_clr_i) r_underflow <= 1'b0;
    end
  end

  assign w_overflow_o  = r_overflow;
  assign r_underflow_o = r_underflow;
`endif

endmodule
